knc_chunk_feeder: RTL and testbench

Upstream feeder for the cipher core's key/nonce/counter chunk port. It holds a host-programmed 256-bit key, 96-bit nonce and 32-bit block counter. It answers each core `chunk_request` with exactly one `chunk_valid` pulse carrying the requested 32-bit word. It also advances the block counter after every completed block, so consecutive blocks use successive counters without host intervention.

---
 rtl/knc_chunk_feeder.sv | 153 +++++++++++++++
 tb/tb_knc_chunk_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knc_chunk_feeder.sv
// Key/nonce/counter chunk feeder: serves one 32-bit word per new core request and
// advances the block counter on block_done when AUTO_INC is set.
module knc_chunk_feeder #(
   parameter int AUTO_INC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        chunk_request,
   input  logic [1:0]  request_type,
   input  logic [4:0]  chunk_index,
   input  logic        block_done,
   output logic [1:0]  chunk_type,
   output logic        chunk_valid,
   output logic [31:0] chunk,
   output logic        cfg_locked,
   output logic        cfg_reject,
   output logic        req_err
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] key_q [8];
   logic [31:0] nonce_q [3];
   logic [31:0] ctr_q;
   logic [6:0]  tag_q, tag_d;
   logic        served_vld_q, served_vld_d;
   logic [1:0]  chunk_type_q;
   logic        chunk_valid_q;
   logic [31:0] chunk_q;
   logic        reject_q;
   logic        req_err_q;

   logic [6:0]  req_tag;
   logic        req_new;
   logic        req_legal;
   logic [31:0] sel_word;
   logic        wr_ok;
   logic        wr_rej;
   logic [11:0] wr_en;

   assign req_tag = {request_type, chunk_index};
   assign req_new = chunk_request && (!served_vld_q || (req_tag != tag_q));
   assign wr_ok   = cfg_we && (state_q == IDLE) && (cfg_addr <= 4'd11);
   assign wr_rej  = cfg_we && !wr_ok;

   for (genvar gi = 0; gi < 12; gi++) begin : g_wr_en
      assign wr_en[gi] = wr_ok && (cfg_addr == 4'(gi));
   end

   always_comb begin
      req_legal = 1'b0;
      sel_word  = ctr_q;
      case (request_type)
         2'b00: begin
            req_legal = (chunk_index <= 5'd7);
            sel_word  = key_q[chunk_index[2:0]];
         end
         2'b01: begin
            req_legal = (chunk_index <= 5'd2);
            if (chunk_index[1:0] == 2'd2)
               sel_word = nonce_q[2];
            else if (chunk_index[0])
               sel_word = nonce_q[1];
            else
               sel_word = nonce_q[0];
         end
         2'b10: begin
            req_legal = (chunk_index == 5'd0);
            sel_word  = ctr_q;
         end
         default: req_legal = 1'b0;
      endcase
   end

   // Serving the counter word ends a sequence and forgets the tag so the next
   // block's identical key/nonce/counter tags are treated as new again.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      served_vld_d = served_vld_q;
      if (req_new) begin
         tag_d        = req_tag;
         served_vld_d = 1'b1;
         if (req_legal && request_type == 2'b00) begin
            state_d = LOCKED;
         end else if (req_legal && request_type == 2'b10) begin
            state_d      = IDLE;
            served_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         tag_q         <= '0;
         served_vld_q  <= 1'b0;
         chunk_type_q  <= '0;
         chunk_valid_q <= 1'b0;
         chunk_q       <= '0;
         reject_q      <= 1'b0;
         req_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         tag_q         <= tag_d;
         served_vld_q  <= served_vld_d;
         chunk_valid_q <= req_new && req_legal;
         req_err_q     <= req_new && !req_legal;
         reject_q      <= wr_rej;
         if (req_new && req_legal) begin
            chunk_q      <= sel_word;
            chunk_type_q <= request_type;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rst)
            key_q[i] <= '0;
         else if (wr_en[i])
            key_q[i] <= cfg_wdata;
      end
      for (int i = 0; i < 3; i++) begin
         if (rst)
            nonce_q[i] <= '0;
         else if (wr_en[8+i])
            nonce_q[i] <= cfg_wdata;
      end
   end

   // A host counter write takes priority over the block_done increment.
   always_ff @(posedge clk) begin
      if (rst)
         ctr_q <= '0;
      else if (wr_en[11])
         ctr_q <= cfg_wdata;
      else if (AUTO_INC != 0 && block_done)
         ctr_q <= ctr_q + 32'd1;
   end

   assign chunk_type  = chunk_type_q;
   assign chunk_valid = chunk_valid_q;
   assign chunk       = chunk_q;
   assign cfg_locked  = (state_q == LOCKED);
   assign cfg_reject  = reject_q;
   assign req_err     = req_err_q;

endmodule

// File: tb/tb_knc_chunk_feeder.sv
// Bench for knc_chunk_feeder: directed scenarios plus randomized traffic checked
// against a word-level reference model of the register file and serve rules.
module tb_knc_chunk_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        chunk_request;
   logic [1:0]  request_type;
   logic [4:0]  chunk_index;
   logic        block_done;

   logic [1:0]  chunk_type, type0;
   logic        chunk_valid, valid0;
   logic [31:0] chunk, chunk0;
   logic        cfg_locked, locked0;
   logic        cfg_reject, reject0;
   logic        req_err, err0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   knc_chunk_feeder #(.AUTO_INC(1)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
      .block_done(block_done), .chunk_type(chunk_type), .chunk_valid(chunk_valid),
      .chunk(chunk), .cfg_locked(cfg_locked), .cfg_reject(cfg_reject), .req_err(req_err)
   );

   knc_chunk_feeder #(.AUTO_INC(0)) dut0 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
      .block_done(block_done), .chunk_type(type0), .chunk_valid(valid0),
      .chunk(chunk0), .cfg_locked(locked0), .cfg_reject(reject0), .req_err(err0)
   );

   // Reference model: register file contents plus the expected registered outputs.
   logic [31:0] m_key [8];
   logic [31:0] m_nonce [3];
   logic [31:0] m_ctr, m_ctr0;
   logic        m_locked, m_sv;
   logic [6:0]  m_tag;
   logic        e_valid, e_err, e_reject;
   logic [1:0]  e_type;
   logic [31:0] e_chunk, e_chunk0;
   logic        t_new, t_legal, t_lock, t_acc;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_key[i] = '0;
         for (int i = 0; i < 3; i++) m_nonce[i] = '0;
         m_ctr = '0; m_ctr0 = '0; m_locked = 0; m_sv = 0; m_tag = '0;
         e_valid = 0; e_err = 0; e_reject = 0; e_type = '0; e_chunk = '0; e_chunk0 = '0;
      end else begin
         t_new   = chunk_request && (!m_sv || ({request_type, chunk_index} != m_tag));
         t_legal = (request_type == 2'd0 && chunk_index < 8) ||
                   (request_type == 2'd1 && chunk_index < 3) ||
                   (request_type == 2'd2 && chunk_index == 0);
         t_lock  = m_locked;
         e_valid = 0;
         e_err   = 0;
         if (t_new) begin
            m_tag = {request_type, chunk_index};
            m_sv  = 1;
            if (t_legal) begin
               e_valid = 1;
               e_type  = request_type;
               if (request_type == 2'd0) begin
                  e_chunk = m_key[chunk_index[2:0]];
                  e_chunk0 = e_chunk;
                  t_lock = 1;
               end else if (request_type == 2'd1) begin
                  e_chunk = m_nonce[chunk_index[1:0]];
                  e_chunk0 = e_chunk;
               end else begin
                  e_chunk = m_ctr;
                  e_chunk0 = m_ctr0;
                  t_lock = 0;
                  m_sv = 0;
               end
            end else begin
               e_err = 1;
            end
         end
         t_acc    = cfg_we && !m_locked && (cfg_addr < 12);
         e_reject = cfg_we && !t_acc;
         if (t_acc && cfg_addr < 8) m_key[cfg_addr[2:0]] = cfg_wdata;
         if (t_acc && cfg_addr >= 8 && cfg_addr < 11) m_nonce[cfg_addr[1:0]] = cfg_wdata;
         if (t_acc && cfg_addr == 11) begin
            m_ctr = cfg_wdata;
            m_ctr0 = cfg_wdata;
         end else if (block_done) begin
            m_ctr = m_ctr + 1;
         end
         m_locked = t_lock;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic set_req(input logic [1:0] t, input logic [4:0] idx);
      chunk_request = 1; request_type = t; chunk_index = idx;
   endtask

   task automatic test_reset();
      rst = 1; chunk_request = 0; cfg_we = 0; block_done = 0;
      tick(); tick();
      rst = 0;
      checks++; if (chunk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", chunk_valid); end
      checks++; if (chunk !== 32'h0) begin errors++; $display("FAIL reset_chunk got=%h exp=0", chunk); end
      checks++; if (chunk_type !== 2'b00) begin errors++; $display("FAIL reset_type got=%0h exp=0", chunk_type); end
      checks++; if (cfg_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0h exp=0", cfg_locked); end
      checks++; if (cfg_reject !== 1'b0) begin errors++; $display("FAIL reset_reject got=%0h exp=0", cfg_reject); end
      checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", req_err); end
      $display("reset done");
   endtask

   task automatic test_program_serve();
      logic [31:0] kw [8];
      logic [31:0] nw [3];
      logic [31:0] exp_word;
      logic [1:0]  t;
      logic [4:0]  idx;
      int          hold, pulses;
      logic [31:0] key0_word, ctr_word;
      kw = '{32'h05060708, 32'h01020304, 32'hCAFEF00D, 32'hDEADBEEF,
             32'h05060708, 32'h01020304, 32'hCAFEF00D, 32'hDEADBEEF};
      nw = '{32'hFEDCBA98, 32'h9ABCDEF0, 32'h12345678};
      for (int i = 0; i < 12; i++) begin
         if (i < 8) host_write(4'(i), kw[i]);
         else if (i < 11) host_write(4'(i), nw[i-8]);
         else host_write(4'd11, 32'hA0B0C0D0);
         checks++; if (cfg_reject !== 1'b0) begin errors++; $display("FAIL prog_reject addr=%0d got=%0h exp=0", i, cfg_reject); end
      end
      pulses = 0; key0_word = '0; ctr_word = '0;
      for (int r = 0; r < 12; r++) begin
         t   = (r < 8) ? 2'd0 : (r < 11) ? 2'd1 : 2'd2;
         idx = (r < 8) ? 5'(r) : (r < 11) ? 5'(r - 8) : 5'd0;
         exp_word = (r < 8) ? kw[r] : (r < 11) ? nw[r-8] : 32'hA0B0C0D0;
         hold = (r == 11) ? 1 : 2;
         set_req(t, idx);
         for (int h = 0; h < hold; h++) begin
            tick();
            checks++; if (chunk_valid !== (h == 0)) begin errors++; $display("FAIL serve_valid req=%0d cyc=%0d got=%0h exp=%0h", r, h, chunk_valid, (h == 0)); end
            if (chunk_valid === 1'b1) begin
               pulses++;
               $display("chunk type=%0d idx=%0d word=%h locked=%0d", chunk_type, idx, chunk, cfg_locked);
               if (r == 0) key0_word = chunk;
               if (r == 11) ctr_word = chunk;
               checks++; if (chunk !== exp_word) begin errors++; $display("FAIL serve_word req=%0d got=%h exp=%h", r, chunk, exp_word); end
               checks++; if (chunk_type !== t) begin errors++; $display("FAIL serve_type req=%0d got=%0h exp=%0h", r, chunk_type, t); end
               checks++; if (cfg_locked !== (t != 2'd2)) begin errors++; $display("FAIL serve_locked req=%0d got=%0h exp=%0h", r, cfg_locked, (t != 2'd2)); end
            end
         end
      end
      chunk_request = 0;
      tick();
      checks++; if (pulses != 12) begin errors++; $display("FAIL serve_pulses got=%0d exp=12", pulses); end
      checks++; if (key0_word !== 32'h05060708) begin errors++; $display("FAIL serve_key0 got=%h exp=05060708", key0_word); end
      checks++; if (ctr_word !== 32'hA0B0C0D0) begin errors++; $display("FAIL serve_ctr got=%h exp=a0b0c0d0", ctr_word); end
   endtask

   task automatic test_locked_write();
      set_req(2'd0, 5'd0); tick(); chunk_request = 0;
      checks++; if (cfg_locked !== 1'b1) begin errors++; $display("FAIL lockw_locked got=%0h exp=1", cfg_locked); end
      host_write(4'd0, 32'h11111111);
      checks++; if (cfg_reject !== 1'b1) begin errors++; $display("FAIL lockw_reject got=%0h exp=1", cfg_reject); end
      tick();
      checks++; if (cfg_reject !== 1'b0) begin errors++; $display("FAIL lockw_reject_clr got=%0h exp=0", cfg_reject); end
      set_req(2'd0, 5'd1); tick();
      set_req(2'd0, 5'd0); tick();
      checks++; if (chunk !== 32'h05060708 || chunk_valid !== 1'b1) begin errors++; $display("FAIL lockw_key0 got=%h/%0h exp=05060708/1", chunk, chunk_valid); end
      set_req(2'd2, 5'd0); tick(); chunk_request = 0;
      checks++; if (cfg_locked !== 1'b0) begin errors++; $display("FAIL lockw_unlock got=%0h exp=0", cfg_locked); end
      $display("locked write rejected");
   endtask

   task automatic test_autoinc_wrap();
      host_write(4'd11, 32'hFFFFFFFF);
      block_done = 1; tick(); block_done = 0;
      set_req(2'd2, 5'd0); tick(); chunk_request = 0;
      checks++; if (chunk_valid !== 1'b1 || chunk !== 32'h00000000) begin errors++; $display("FAIL wrap_inc got=%h/%0h exp=00000000/1", chunk, chunk_valid); end
      checks++; if (chunk0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_noinc got=%h exp=ffffffff", chunk0); end
      $display("wrap counter=%h noinc=%h", chunk, chunk0);
   endtask

   task automatic test_same_cycle();
      cfg_we = 1; cfg_addr = 4'd11; cfg_wdata = 32'h5; block_done = 1;
      tick();
      cfg_we = 0; block_done = 0;
      set_req(2'd2, 5'd0); tick();
      checks++; if (chunk !== 32'h5) begin errors++; $display("FAIL same_write got=%h exp=00000005", chunk); end
      checks++; if (chunk0 !== 32'h5) begin errors++; $display("FAIL same_write0 got=%h exp=00000005", chunk0); end
      block_done = 1; tick(); block_done = 0;
      checks++; if (chunk_valid !== 1'b1 || chunk !== 32'h5) begin errors++; $display("FAIL same_preinc got=%h/%0h exp=00000005/1", chunk, chunk_valid); end
      tick(); chunk_request = 0;
      checks++; if (chunk_valid !== 1'b1 || chunk !== 32'h6) begin errors++; $display("FAIL same_postinc got=%h/%0h exp=00000006/1", chunk, chunk_valid); end
      checks++; if (chunk0 !== 32'h5) begin errors++; $display("FAIL same_noinc got=%h exp=00000005", chunk0); end
      $display("same-cycle counter=%h", chunk);
   endtask

   task automatic test_illegal();
      int errp, vp;
      errp = 0; vp = 0;
      set_req(2'd3, 5'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         errp += int'(req_err === 1'b1); vp += int'(chunk_valid === 1'b1);
      end
      set_req(2'd1, 5'd3);
      for (int i = 0; i < 2; i++) begin
         tick();
         errp += int'(req_err === 1'b1); vp += int'(chunk_valid === 1'b1);
      end
      chunk_request = 0; tick();
      errp += int'(req_err === 1'b1); vp += int'(chunk_valid === 1'b1);
      checks++; if (errp != 2) begin errors++; $display("FAIL illegal_errs got=%0d exp=2", errp); end
      checks++; if (vp != 0) begin errors++; $display("FAIL illegal_valid got=%0d exp=0", vp); end
      $display("illegal requests err_pulses=%0d", errp);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i <= 4; i++) begin
         set_req(2'd0, 5'(i)); tick();
      end
      chunk_request = 0;
      checks++; if (cfg_locked !== 1'b1) begin errors++; $display("FAIL rmid_locked got=%0h exp=1", cfg_locked); end
      rst = 1; tick(); rst = 0;
      checks++; if (cfg_locked !== 1'b0) begin errors++; $display("FAIL rmid_unlocked got=%0h exp=0", cfg_locked); end
      set_req(2'd0, 5'd4); tick();
      checks++; if (chunk_valid !== 1'b1 || chunk !== 32'h0) begin errors++; $display("FAIL rmid_rereq got=%h/%0h exp=00000000/1", chunk, chunk_valid); end
      set_req(2'd2, 5'd0); tick(); chunk_request = 0;
      $display("reset mid-sequence re-request word=%h", chunk);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst        = ($urandom_range(0, 99) == 0);
         cfg_we     = ($urandom_range(0, 3) == 0);
         cfg_addr   = 4'($urandom_range(0, 15));
         cfg_wdata  = $urandom;
         block_done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) begin
            chunk_request = ($urandom_range(0, 3) != 0);
            request_type  = 2'($urandom_range(0, 3));
            chunk_index   = 5'($urandom_range(0, 8));
         end
         tick();
         checks++; if (chunk_valid !== e_valid || valid0 !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0h/%0h exp=%0h", c, chunk_valid, valid0, e_valid); end
         checks++; if (req_err !== e_err || err0 !== e_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0h/%0h exp=%0h", c, req_err, err0, e_err); end
         checks++; if (cfg_reject !== e_reject || reject0 !== e_reject) begin errors++; $display("FAIL rnd_reject cyc=%0d got=%0h/%0h exp=%0h", c, cfg_reject, reject0, e_reject); end
         checks++; if (cfg_locked !== m_locked || locked0 !== m_locked) begin errors++; $display("FAIL rnd_locked cyc=%0d got=%0h/%0h exp=%0h", c, cfg_locked, locked0, m_locked); end
         checks++; if (chunk_type !== e_type || type0 !== e_type) begin errors++; $display("FAIL rnd_type cyc=%0d got=%0h/%0h exp=%0h", c, chunk_type, type0, e_type); end
         checks++; if (chunk !== e_chunk) begin errors++; $display("FAIL rnd_chunk cyc=%0d got=%h exp=%h", c, chunk, e_chunk); end
         checks++; if (chunk0 !== e_chunk0) begin errors++; $display("FAIL rnd_chunk0 cyc=%0d got=%h exp=%h", c, chunk0, e_chunk0); end
      end
      rst = 0; cfg_we = 0; block_done = 0; chunk_request = 0;
      tick();
      $display("random traffic done");
   endtask

   initial begin
      rst = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
      chunk_request = 0; request_type = '0; chunk_index = '0; block_done = 0;
      test_reset();
      test_program_serve();
      test_locked_write();
      test_autoinc_wrap();
      test_same_cycle();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
